// File: rtl/grf_write_arbiter_pkg.sv
// Shared types for the GRF write-back arbiter.
// Write record carried from the pipeline/MDU to the register file.
package grf_write_arbiter_pkg;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_rec_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bus bundle between the write-back sources and the arbiter.
// master drives the sources and lookups, slave is the arbiter.
interface grf_write_arbiter_if;

    logic        pipe_valid;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        mdu_valid;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;
    logic        mdu_ready;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] PC_backD;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        pend1;
    logic        pend2;

    modport master (
        output pipe_valid, pipe_a3, pipe_wd, pipe_pc,
        output mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        output q1, q2,
        input  mdu_ready, WE, A3, WD3, PC_backD, pend1, pend2
    );

    modport slave (
        input  pipe_valid, pipe_a3, pipe_wd, pipe_pc,
        input  mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        input  q1, q2,
        output mdu_ready, WE, A3, WD3, PC_backD, pend1, pend2
    );

endinterface

// File: rtl/grf_write_arbiter_wb_fifo.sv
// In-order queue of MDU write records awaiting a free write slot.
// Exposes the raw entry array plus a per-slot valid mask for lookups.
module wb_fifo
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  wr_rec_t                i_rec,
    input  logic                   i_pop,
    output wr_rec_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output wr_rec_t                o_mem [DEPTH],
    output logic [DEPTH-1:0]       o_vld
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_cnt;
    wr_rec_t       r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rptr];
    assign o_mem   = r_mem;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_rec;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        o_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_vld[i] = ({1'b0, PW'(i) - r_rptr} < r_cnt);
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// Register-file write arbiter: pipeline has priority, MDU results queue.
// Define GRF_WB_PENDING_EN to build the q1/q2 pending-lookup comparators.
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    grf_write_arbiter_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    wr_rec_t          w_pipe_rec;
    wr_rec_t          w_mdu_rec;
    wr_rec_t          w_head;
    wr_rec_t          w_mem [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pipe_q;
    logic             w_acc;
    logic             w_push;
    logic             w_pop;
    logic             r_we;
    wr_rec_t          r_rec;

    assign w_pipe_rec = '{a3: bus.pipe_a3, wd: bus.pipe_wd, pc: bus.pipe_pc};
    assign w_mdu_rec  = '{a3: bus.mdu_a3, wd: bus.mdu_wd, pc: bus.mdu_pc};
    assign w_pipe_q   = bus.pipe_valid && (bus.pipe_a3 != REG_ZERO);

    // Readiness depends only on stored occupancy, never on this cycle's pop.
    assign bus.mdu_ready = reset && (w_count < CW'(DEPTH));
    assign w_acc  = bus.mdu_valid && bus.mdu_ready;
    assign w_push = w_acc && (bus.mdu_a3 != REG_ZERO) && !w_full;
    assign w_pop  = !w_pipe_q && !w_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_rec   (w_mdu_rec),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_mem   (w_mem),
        .o_vld   (w_vld)
    );

    // Write port: pipe first, else FIFO head, else idle holding last fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we  <= 1'b0;
            r_rec <= '0;
        end else if (w_pipe_q) begin
            r_we  <= 1'b1;
            r_rec <= w_pipe_rec;
        end else if (w_pop) begin
            r_we  <= 1'b1;
            r_rec <= w_head;
        end else begin
            r_we  <= 1'b0;
        end
    end

    assign bus.WE       = r_we;
    assign bus.A3       = r_rec.a3;
    assign bus.WD3      = r_rec.wd;
    assign bus.PC_backD = r_rec.pc;

`ifdef GRF_WB_PENDING_EN
    logic w_hit1;
    logic w_hit2;

    // Scan live queue entries for the looked-up destinations.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i] && (w_mem[i].a3 == bus.q1)) w_hit1 = 1'b1;
            if (w_vld[i] && (w_mem[i].a3 == bus.q2)) w_hit2 = 1'b1;
        end
    end

    assign bus.pend1 = w_hit1 && (bus.q1 != REG_ZERO);
    assign bus.pend2 = w_hit2 && (bus.q2 != REG_ZERO);
`else
    logic w_unused_pend;

    // Lookup inputs and entry view are intentionally left unconsumed.
    always_comb begin
        w_unused_pend = ^{bus.q1, bus.q2, w_vld};
        for (int i = 0; i < DEPTH; i++) begin
            w_unused_pend = w_unused_pend ^ (^w_mem[i]);
        end
    end

    assign bus.pend1 = 1'b0;
    assign bus.pend2 = 1'b0;
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter against a queue-based model.
// Honours GRF_WB_PENDING_EN for the expected pend1/pend2 values.
module tb_grf_write_arbiter;
    import grf_write_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    wr_rec_t mq[$];
    wr_rec_t offers[$];
    logic    e_we = 1'b0;
    wr_rec_t e_rec = '0;
    bit      last_acc = 1'b0;

    grf_write_arbiter_if bus ();

    grf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pend(input logic [4:0] q);
        logic hit = 1'b0;
`ifdef GRF_WB_PENDING_EN
        if (q != 5'd0)
            foreach (mq[i]) if (mq[i].a3 == q) hit = 1'b1;
`endif
        return hit;
    endfunction

    task automatic set_pipe(input logic v, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] p);
        bus.pipe_valid = v;
        bus.pipe_a3    = a;
        bus.pipe_wd    = d;
        bus.pipe_pc    = p;
    endtask

    task automatic drive_offer();
        bus.mdu_valid = (offers.size() > 0);
        if (offers.size() > 0) begin
            bus.mdu_a3 = offers[0].a3;
            bus.mdu_wd = offers[0].wd;
            bus.mdu_pc = offers[0].pc;
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".WE"}, 32'(bus.WE), 32'(e_we));
        chk({tag, ".A3"}, 32'(bus.A3), 32'(e_rec.a3));
        chk({tag, ".WD3"}, bus.WD3, e_rec.wd);
        chk({tag, ".PC"}, bus.PC_backD, e_rec.pc);
    endtask

    // One clock: check lookups/ready, advance model, check write port.
    task automatic cycle();
        bit acc;
        #1;
        chk("mdu_ready", 32'(bus.mdu_ready), 32'(mq.size() < DEPTH));
        chk("pend1", 32'(bus.pend1), 32'(exp_pend(bus.q1)));
        chk("pend2", 32'(bus.pend2), 32'(exp_pend(bus.q2)));
        acc = bus.mdu_valid && (mq.size() < DEPTH);
        if (bus.pipe_valid && bus.pipe_a3 != 5'd0) begin
            e_we  = 1'b1;
            e_rec = '{a3: bus.pipe_a3, wd: bus.pipe_wd, pc: bus.pipe_pc};
        end else if (mq.size() > 0) begin
            e_we  = 1'b1;
            e_rec = mq.pop_front();
        end else begin
            e_we = 1'b0;
        end
        if (acc && bus.mdu_a3 != 5'd0)
            mq.push_back('{a3: bus.mdu_a3, wd: bus.mdu_wd, pc: bus.mdu_pc});
        last_acc = acc;
        @(posedge clk);
        #1;
        check_out("wb");
        @(negedge clk);
        if (acc && offers.size() > 0) void'(offers.pop_front());
    endtask

    initial begin
        set_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        bus.mdu_valid = 1'b0;
        bus.mdu_a3 = '0;
        bus.mdu_wd = '0;
        bus.mdu_pc = '0;
        bus.q1 = '0;
        bus.q2 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_out("rst");
        chk("rst.ready", 32'(bus.mdu_ready), 32'd0);
        chk("rst.pend1", 32'(bus.pend1), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.ready", 32'(bus.mdu_ready), 32'd1);

        // Single pipe write appears next cycle
        set_pipe(1'b1, 5'd5, 32'h1234, 32'h3000);
        cycle();
        set_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        cycle();
        cycle();

        // MDU result queued behind a busy pipe, looked up by q1
        bus.q1 = 5'd8;
        offers.push_back('{a3: 5'd8, wd: 32'hAA, pc: 32'h4000});
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, 5'(k + 1), 32'(k), 32'h5000 + 32'(k));
            drive_offer();
            cycle();
        end
        set_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        drive_offer();
        cycle();
        cycle();

        // Three back-to-back offers overflow a depth-2 queue
        for (int k = 0; k < 3; k++)
            offers.push_back('{a3: 5'(10 + k), wd: 32'hB0 + 32'(k),
                               pc: 32'h6000 + 32'(k)});
        for (int k = 0; k < 9; k++) begin
            if (k < 4) set_pipe(1'b1, 5'd1, 32'hC0 + 32'(k), 32'h7000);
            else set_pipe(1'b0, 5'd0, 32'd0, 32'd0);
            drive_offer();
            cycle();
        end

        // Pipe with a3=0 frees the slot for the queue head
        offers.push_back('{a3: 5'd3, wd: 32'h55, pc: 32'h8000});
        set_pipe(1'b1, 5'd2, 32'h1, 32'h8100);
        drive_offer();
        cycle();
        drive_offer();
        set_pipe(1'b1, 5'd0, 32'h99, 32'h8200);
        cycle();
        set_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        cycle();

        // Mid-operation reset with two queued entries
        bus.q1 = 5'd20;
        offers.push_back('{a3: 5'd20, wd: 32'hD0, pc: 32'h9000});
        offers.push_back('{a3: 5'd21, wd: 32'hD1, pc: 32'h9004});
        for (int k = 0; k < 2; k++) begin
            set_pipe(1'b1, 5'd4, 32'hE0, 32'h9100);
            drive_offer();
            cycle();
        end
        chk("pre_rst.depth", 32'(mq.size()), 32'd2);
        rst_n = 1'b0;
        mq.delete();
        e_we = 1'b0;
        e_rec = '0;
        #1;
        check_out("mid_rst");
        chk("mid_rst.ready", 32'(bus.mdu_ready), 32'd0);
        chk("mid_rst.pend1", 32'(bus.pend1), 32'd0);
        @(posedge clk);
        #1;
        check_out("mid_rst2");
        @(negedge clk);
        rst_n = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        bus.mdu_valid = 1'b0;
        repeat (4) cycle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if (!bus.mdu_valid || last_acc) begin
                offers.delete();
                if ($urandom_range(0, 9) < 6)
                    offers.push_back('{a3: 5'($urandom_range(0, 7)),
                                       wd: $urandom, pc: $urandom});
            end
            set_pipe(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom);
            bus.q1 = 5'($urandom_range(0, 7));
            bus.q2 = 5'($urandom_range(0, 7));
            drive_offer();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_write_arbiter.md
GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

Interface
REQ-001 Parameter: DEPTH, default 2, number of MDU result FIFO entries (power of two, 2..8).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: pipe_valid  input  1  pipeline write-back result present this cycle; cannot be stalled.
REQ-005 Port: pipe_a3 / pipe_wd / pipe_pc  input  5/32/32  pipeline destination, data, instruction PC.
REQ-006 Port: mdu_valid  input  1  MDU result offered; held stable until accepted.
REQ-007 Port: mdu_a3 / mdu_wd / mdu_pc  input  5/32/32  MDU destination, data, PC.
REQ-008 Port: mdu_ready  output  1  FIFO can accept; transfer when mdu_valid && mdu_ready.
REQ-009 Port: WE / A3 / WD3 / PC_backD  output  1/5/32/32  registered register-file write port.
REQ-010 Port: q1 / q2  input  5/5  hazard-lookup register numbers.
REQ-011 Port: pend1 / pend2  output  1/1  q1 / q2 has a result still queued.

Function
REQ-012 Write port SHALL be registered; all four outputs update only on rising clk.
REQ-013 Pipe write qualifies when pipe_valid=1 and pipe_a3!=0; pipe_valid with pipe_a3=0 SHALL be dropped and the slot treated as free.
REQ-014 Qualified pipe write in cycle N SHALL appear as WE=1, A3/WD3/PC_backD = pipe fields during cycle N+1.
REQ-015 Pipe SHALL have strict priority; the FIFO head pops only in a cycle with no qualified pipe write.
REQ-016 Every MDU result SHALL pass through the FIFO; push in cycle N gives earliest WE=1 in cycle N+2.
REQ-017 MDU results with mdu_a3=0 SHALL be accepted (handshake completes) but not pushed.
REQ-018 FIFO SHALL be in-order; read/write pointers wrap modulo DEPTH; an occupancy counter of width clog2(DEPTH)+1 SHALL distinguish full from empty.
REQ-019 mdu_ready SHALL equal (count < DEPTH), from registered state only; no same-cycle pop-to-push pass-through.
REQ-020 Simultaneous push and pop in one cycle SHALL leave count unchanged.
REQ-021 With no qualified pipe write and empty FIFO, WE SHALL be 0 next cycle and A3/WD3/PC_backD SHALL hold their values.
REQ-022 pendX SHALL be combinational: 1 iff qX!=0 and some valid FIFO entry has a3==qX; the output register is excluded.

Reset
REQ-023 While reset=0: WE=0, A3=0, WD3=0, PC_backD=0, pointers=0, count=0, mdu_ready=0, pend1=pend2=0.
REQ-024 Reset mid-operation SHALL discard all queued entries and any accepted-but-unwritten result.
REQ-025 First cycle after reset release: mdu_ready=1.

Configuration
REQ-026 Macro GRF_WB_PENDING_EN defined: q1/q2/pend1/pend2 logic implemented per REQ-022.
REQ-027 Macro undefined: ports remain, pend1=pend2=0 constantly, q1/q2 ignored, no comparators synthesized.

Structure
REQ-028 Shared package SHALL hold the write-record struct {a3[4:0], wd[31:0], pc[31:0]} and constant REG_ZERO=5'd0.
REQ-029 Sub-module wb_fifo (parameter DEPTH, push/pop/full/empty/count, entry-array view for pending compare) SHALL hold the FIFO; arbitration and output register stay in the top.

Verification
REQ-030 pipe_valid=1, a3=5, wd=0x1234, pc=0x3000 at cycle N -> cycle N+1: WE=1, A3=5, WD3=0x1234, PC_backD=0x3000.
REQ-031 MDU a3=8, wd=0xAA pushed at N while pipe writes every cycle N..N+3 -> pend(q=8)=1 throughout; entry written in the cycle after pipe goes idle.
REQ-032 DEPTH=2: three back-to-back MDU offers with pipe busy -> mdu_ready=0 after second push; third held and accepted once a pop frees space; writes in push order.
REQ-033 pipe_valid=1, pipe_a3=0 with FIFO head a3=3, wd=0x55 -> next cycle WE=1, A3=3, WD3=0x55.
REQ-034 FIFO holding two entries, reset=0 for one cycle -> WE=0, count=0, mdu_ready=0 during reset, mdu_ready=1 after release, no queued entry ever written.
REQ-035 Build without GRF_WB_PENDING_EN, queue entry a3=7, q1=7 -> pend1=0.
